btb_predictor: RTL and testbench

- Branch target buffer with per-entry 2-bit saturating counters. It sits in the IF stage and is trained from the EX-stage branch decision logic.
- Each cycle it looks up the fetch PC combinationally and produces the taken prediction and predicted target. These travel down the pipe to EX, where they are compared with the resolved outcome.
- It is updated on the clock edge from the EX resolution (actual taken, target, mispredict/type-error flag).

---
 rtl/btb_predictor.sv | 169 ++++++++++++++++
 tb/tb_btb_predictor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry 2-bit saturating counters, trained from EX resolution.
// Latency: lookup is combinational (zero cycles); updates land on the next rising clk edge.
// Backpressure: none; lookup ignores stalls, flush_all beats a same-cycle update.
// Optional BTB_PERF_CNT_EN adds 32-bit wrapping lookup-hit / resolved / mispredict counters.
module btb_predictor #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] if_pc,
    output logic                 bp_taken,
    output logic [BUS_WIDTH-1:0] bp_target,
    input  logic                 upd_valid,
    input  logic [BUS_WIDTH-1:0] upd_pc,
    input  logic [BUS_WIDTH-1:0] upd_target,
    input  logic                 upd_taken,
    input  logic                 upd_is_br,
    input  logic                 upd_mispredict,
`ifdef BTB_PERF_CNT_EN
    output logic [31:0]          perf_lookup_hit,
    output logic [31:0]          perf_resolved,
    output logic [31:0]          perf_mispredict,
`endif
    input  logic                 flush_all
);

    // Index width is derived from the table depth and is not meant to be overridden.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = BUS_WIDTH - IDX_W - 2;

    // Table storage: one valid bit, tag, target and 2-bit counter per entry.
    logic [DEPTH-1:0]     valid;
    logic [TAG_W-1:0]     tag    [DEPTH];
    logic [BUS_WIDTH-1:0] target [DEPTH];
    logic [1:0]           ctr    [DEPTH];

    // Lookup side address split (pc[1:0] never participates).
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    // Update side address split and decoded actions.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_en;
    logic             do_inval;
    logic             do_inc;
    logic             do_dec;
    logic             do_alloc;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[BUS_WIDTH-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[BUS_WIDTH-1:IDX_W+2];

    // Combinational lookup; sees pre-update contents since there is no write bypass.
    always_comb begin
        lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
        bp_taken  = lk_hit && ctr[lk_idx][1];
        bp_target = bp_taken ? target[lk_idx] : '0;
    end

    // Decode the EX resolution into exactly one table action; flush drops the update.
    always_comb begin
        up_hit   = valid[up_idx] && (tag[up_idx] == up_tag);
        up_en    = upd_valid && !flush_all;
        do_inval = 1'b0;
        do_inc   = 1'b0;
        do_dec   = 1'b0;
        do_alloc = 1'b0;
        if (up_en) begin
            if (!upd_is_br) begin
                // Type error: a non-branch aliased onto this entry.
                do_inval = 1'b1;
            end else if (upd_taken) begin
                do_inc   = up_hit;
                do_alloc = !up_hit;
            end else begin
                // Not-taken branches train an existing entry but never allocate.
                do_dec   = up_hit;
            end
        end
    end

    // Valid bits: flush clears all, invalidate clears one, allocate sets one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (do_inval) begin
            valid[up_idx] <= 1'b0;
        end else if (do_alloc) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Tags change only on allocation; a replaced occupant is simply overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag[i] <= '0;
            end
        end else if (do_alloc) begin
            tag[up_idx] <= up_tag;
        end
    end

    // Targets refresh on every taken resolution that lands in the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                target[i] <= '0;
            end
        end else if (do_alloc || do_inc) begin
            target[up_idx] <= upd_target;
        end
    end

    // Saturating counters: reset weakly not-taken, allocate weakly taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (do_alloc) begin
            ctr[up_idx] <= 2'b10;
        end else if (do_inc) begin
            if (ctr[up_idx] != 2'b11) begin
                ctr[up_idx] <= ctr[up_idx] + 2'd1;
            end
        end else if (do_dec) begin
            if (ctr[up_idx] != 2'b00) begin
                ctr[up_idx] <= ctr[up_idx] - 2'd1;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    // Statistics counters; they wrap freely and ignore flush_all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookup_hit <= '0;
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else begin
            if (bp_taken) begin
                perf_lookup_hit <= perf_lookup_hit + 32'd1;
            end
            if (upd_valid) begin
                perf_resolved <= perf_resolved + 32'd1;
            end
            if (upd_valid && upd_mispredict) begin
                perf_mispredict <= perf_mispredict + 32'd1;
            end
        end
    end

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};
`else
    // Byte-offset bits and the mispredict flag have no consumer without the statistics.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (DEPTH=16): allocation, counter training, invalidation, flush, reset.
module tb_btb_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_br;
    logic        upd_mispredict;
    logic        flush_all;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookup_hit;
    logic [31:0] perf_resolved;
    logic [31:0] perf_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    btb_predictor #(.BUS_WIDTH(32), .DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_is_br      (upd_is_br),
        .upd_mispredict (upd_mispredict),
`ifdef BTB_PERF_CNT_EN
        .perf_lookup_hit(perf_lookup_hit),
        .perf_resolved  (perf_resolved),
        .perf_mispredict(perf_mispredict),
`endif
        .flush_all      (flush_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic br, input logic mp);
        upd_valid      = v;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_is_br      = br;
        upd_mispredict = mp;
    endtask

    task automatic idle();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Apply one update for exactly one edge, then return to idle.
    task automatic one_upd(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic br, input logic mp);
        upd(1'b1, pc, tgt, tk, br, mp);
        tick();
        idle();
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, ".taken"},  {31'b0, bp_taken}, {31'b0, exp_tk});
        check({tag, ".target"}, bp_target, exp_tgt);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_all = 1'b0;
        if_pc     = 32'h100;
        idle();
        #2;
        look("reset", 32'h100, 1'b0, 32'h0);
`ifdef BTB_PERF_CNT_EN
        check("reset.perf_hit", perf_lookup_hit, 32'h0);
        check("reset.perf_res", perf_resolved, 32'h0);
`endif
        #10;
        rst_n = 1'b1;
        tick();

        // Allocate 0x100 with the lookup on the same index: pre-update view this cycle.
        if_pc = 32'h100;
        upd(1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 1'b0);
        #1;
        check("same_cycle.taken", {31'b0, bp_taken}, 32'h0);
        tick();
        idle();
        look("alloc", 32'h100, 1'b1, 32'h80);
        look("alias", 32'h140, 1'b0, 32'h0);
        look("pc_lsbs_ignored", 32'h103, 1'b1, 32'h80);

        // Training: 10 ->11 ->11 (target refresh), not-taken ->10 ->01 ->00.
        one_upd(32'h100, 32'h84, 1'b1, 1'b1, 1'b0);
        one_upd(32'h100, 32'h88, 1'b1, 1'b1, 1'b0);
        look("ctr11.target_refresh", 32'h100, 1'b1, 32'h88);
        one_upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        look("ctr10_after_nt", 32'h100, 1'b1, 32'h88);
        one_upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        look("ctr01_after_nt", 32'h100, 1'b0, 32'h0);
        one_upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        one_upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        look("ctr00_saturated", 32'h100, 1'b0, 32'h0);
        // From 00, one taken gives 01 (still not taken), a second gives 10.
        one_upd(32'h100, 32'h90, 1'b1, 1'b1, 1'b0);
        look("ctr01_from_00", 32'h100, 1'b0, 32'h0);
        one_upd(32'h100, 32'h94, 1'b1, 1'b1, 1'b0);
        look("ctr10_from_01", 32'h100, 1'b1, 32'h94);

        // Not-taken miss never allocates.
        one_upd(32'h108, 32'h500, 1'b0, 1'b1, 1'b0);
        look("nt_no_alloc", 32'h108, 1'b0, 32'h0);

        // Type error invalidates the entry; a neighbour stays intact.
        one_upd(32'h104, 32'h300, 1'b1, 1'b1, 1'b1);
        one_upd(32'h100, 32'h0, 1'b1, 1'b0, 1'b1);
        look("type_err_inval", 32'h100, 1'b0, 32'h0);
        look("neighbour_kept", 32'h104, 1'b1, 32'h300);

        // Replacement of an occupant by an aliasing taken branch.
        one_upd(32'h144, 32'h400, 1'b1, 1'b1, 1'b0);
        look("replace.new", 32'h144, 1'b1, 32'h400);
        look("replace.old", 32'h104, 1'b0, 32'h0);

        // Flush with a concurrent taken update: the update is dropped.
        one_upd(32'h100, 32'h80, 1'b1, 1'b1, 1'b0);
        look("pre_flush", 32'h100, 1'b1, 32'h80);
        flush_all = 1'b1;
        upd(1'b1, 32'h200, 32'h600, 1'b1, 1'b1, 1'b0);
        tick();
        flush_all = 1'b0;
        idle();
        look("flush.0x100", 32'h100, 1'b0, 32'h0);
        look("flush.0x200", 32'h200, 1'b0, 32'h0);
        look("flush.0x144", 32'h144, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a cycle with an update pending.
        one_upd(32'h100, 32'h80, 1'b1, 1'b1, 1'b0);
        look("pre_reset", 32'h100, 1'b1, 32'h80);
        upd(1'b1, 32'h100, 32'h88, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset.taken", {31'b0, bp_taken}, 32'h0);
        check("async_reset.target", bp_target, 32'h0);
        tick();
        idle();
        #1;
        rst_n = 1'b1;
        look("after_reset", 32'h100, 1'b0, 32'h0);

`ifdef BTB_PERF_CNT_EN
        // Five resolutions (two mispredicts), then three edges with a taken hit.
        if_pc = 32'h0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        one_upd(32'h10C, 32'h700, 1'b1, 1'b1, 1'b1);
        one_upd(32'h110, 32'h710, 1'b1, 1'b1, 1'b1);
        one_upd(32'h10C, 32'h720, 1'b1, 1'b1, 1'b0);
        one_upd(32'h110, 32'h0, 1'b0, 1'b1, 1'b0);
        one_upd(32'h114, 32'h0, 1'b0, 1'b1, 1'b0);
        if_pc = 32'h10C;
        tick();
        tick();
        tick();
        if_pc = 32'h0;
        tick();
        check("perf_resolved",   perf_resolved,   32'd5);
        check("perf_mispredict", perf_mispredict, 32'd2);
        check("perf_lookup_hit", perf_lookup_hit, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100us");
        $fatal(1, "timeout");
    end

endmodule
